// File: rtl/missile_pkg.sv
// Shared types and constants for the player-missile scheduler.
package missile_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLIGHT  = 2'd1,
        EXPLODE = 2'd2
    } slot_state_t;

    localparam logic [7:0] FIRE_KEY_DEF = 8'h1A;
    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } mpos_t;

    // Missile spawns centred on the ship's top edge; wraps modulo 2^10.
    function automatic logic [9:0] launch_x(input logic [9:0] ship_x,
                                            input logic [9:0] ship_sx,
                                            input logic [9:0] msize_x);
        return ship_x + (ship_sx >> 1) - (msize_x >> 1);
    endfunction

endpackage

// File: rtl/missile_scheduler_if.sv
// Bus between ship/keycode logic, the scheduler and the color/collision side.
interface missile_scheduler_if #(
    parameter int NUM_MISSILES = 4
);
    logic [7:0]                   keycode;
    logic [9:0]                   ShipX;
    logic [9:0]                   ShipY;
    logic [9:0]                   Ship_sizeX;
    logic [NUM_MISSILES-1:0]      hit;
    logic [10*NUM_MISSILES-1:0]   MissileX_all;
    logic [10*NUM_MISSILES-1:0]   MissileY_all;
    logic [2*NUM_MISSILES-1:0]    slot_state;
    logic [9:0]                   MissileSX;
    logic [9:0]                   MissileSY;
    logic                         fire_ack;

    modport master (
        output keycode, ShipX, ShipY, Ship_sizeX, hit,
        input  MissileX_all, MissileY_all, slot_state, MissileSX, MissileSY, fire_ack
    );

    modport slave (
        input  keycode, ShipX, ShipY, Ship_sizeX, hit,
        output MissileX_all, MissileY_all, slot_state, MissileSX, MissileSY, fire_ack
    );
endinterface

// File: rtl/missile_slot.sv
// One missile slot: IDLE -> FLIGHT -> (EXPLODE) -> IDLE, one step per frame.
module missile_slot
    import missile_pkg::*;
#(
    parameter int Y_STEP      = 3,
    parameter int EXPL_FRAMES = 4
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        launch,
    input  mpos_t       launch_pos,
    input  logic        hit,
    output mpos_t       pos,
    output slot_state_t state
);
    localparam logic [9:0] YS        = 10'(Y_STEP);
    localparam logic [3:0] EXPL_INIT = 4'(EXPL_FRAMES - 1);

    slot_state_t state_d;
    mpos_t       pos_d;
    logic [3:0]  cnt, cnt_d;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state <= IDLE;
            pos   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pos   <= pos_d;
            cnt   <= cnt_d;
        end
    end

    // Hit outranks top-of-screen retire so a last-frame hit still explodes.
    always_comb begin
        state_d = state;
        pos_d   = pos;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_d = FLIGHT;
                    pos_d   = launch_pos;
                end
            end
            FLIGHT: begin
                if (hit) begin
                    state_d = EXPLODE;
                    cnt_d   = EXPL_INIT;
                end else if (pos.y < YS) begin
                    state_d = IDLE;
                end else begin
                    pos_d.y = pos.y - YS;
                end
            end
            EXPLODE: begin
                if (cnt == 4'd0) state_d = IDLE;
                else             cnt_d   = cnt - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/missile_scheduler.sv
// Missile pool: fire-key arbitration with cooldown, lowest free slot wins.
module missile_scheduler
    import missile_pkg::*;
#(
    parameter int         NUM_MISSILES = 4,
    parameter logic [7:0] FIRE_KEY     = FIRE_KEY_DEF,
    parameter int         COOLDOWN     = 8,
    parameter int         Y_STEP       = 3,
    parameter int         EXPL_FRAMES  = 4,
    parameter int         MSIZE_X      = 4,
    parameter int         MSIZE_Y      = 6
) (
    input logic                frame_clk,
    input logic                Reset,
    missile_scheduler_if.slave bus
);
    localparam logic [9:0] MSX     = 10'(MSIZE_X);
    localparam logic [9:0] MSY     = 10'(MSIZE_Y);
    localparam logic [7:0] CD_INIT = 8'(COOLDOWN);

    logic [7:0]                    cooldown;
    logic                          fire_req;
    logic [NUM_MISSILES-1:0]       idle, launch;
    mpos_t                         lpos;
    mpos_t [NUM_MISSILES-1:0]      pos;
    slot_state_t [NUM_MISSILES-1:0] st;
    logic [10*NUM_MISSILES-1:0]    x_all, y_all;
    logic [2*NUM_MISSILES-1:0]     s_all;

    assign fire_req = (bus.keycode == FIRE_KEY) && (cooldown == 8'd0) &&
                      (|idle) && (bus.ShipY >= MSY);

    // idle & -idle isolates the lowest free slot.
    assign launch = fire_req ? (idle & (~idle + 1'b1)) : '0;

    assign lpos.x = launch_x(bus.ShipX, bus.Ship_sizeX, MSX);
    assign lpos.y = bus.ShipY - MSY;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            cooldown     <= '0;
            bus.fire_ack <= 1'b0;
        end else begin
            bus.fire_ack <= fire_req;
            if (fire_req)              cooldown <= CD_INIT;
            else if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
        missile_slot #(
            .Y_STEP      (Y_STEP),
            .EXPL_FRAMES (EXPL_FRAMES)
        ) u_slot (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .launch     (launch[g]),
            .launch_pos (lpos),
            .hit        (bus.hit[g]),
            .pos        (pos[g]),
            .state      (st[g])
        );
        assign idle[g] = (st[g] == IDLE);
    end

    always_comb begin
        x_all = '0;
        y_all = '0;
        s_all = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            x_all[10*i +: 10] = pos[i].x;
            y_all[10*i +: 10] = pos[i].y;
            s_all[2*i +: 2]   = st[i];
        end
    end

    assign bus.MissileX_all = x_all;
    assign bus.MissileY_all = y_all;
    assign bus.slot_state   = s_all;
    assign bus.MissileSX    = MSX;
    assign bus.MissileSY    = MSY;

endmodule

// File: tb/tb_missile_scheduler.sv
// Directed bench for missile_scheduler: launch, auto-repeat, retire, explode, reset.
module tb_missile_scheduler;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   failures  = 0;

    always #5 frame_clk = ~frame_clk;

    missile_scheduler_if #(.NUM_MISSILES(4)) bus ();

    missile_scheduler #(.NUM_MISSILES(4)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] es;
        int n;

        bus.keycode    = 8'h00;
        bus.hit        = 4'b0000;
        bus.ShipX      = 10'd300;
        bus.Ship_sizeX = 10'd32;
        bus.ShipY      = 10'd400;

        // reset held two frames, then idle with no key
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int f = 0; f < 5; f++) begin
            tick();
            chk("rst_state", 40'(bus.slot_state), 40'h0);
            chk("rst_x",     bus.MissileX_all,    40'h0);
            chk("rst_y",     bus.MissileY_all,    40'h0);
            chk("rst_ack",   40'(bus.fire_ack),   40'h0);
        end
        chk("size_x", 40'(bus.MissileSX), 40'd4);
        chk("size_y", 40'(bus.MissileSY), 40'd6);

        // single launch and first two moves
        bus.keycode = 8'h1A;
        tick();
        bus.keycode = 8'h00;
        chk("l1_ack",   40'(bus.fire_ack),           40'd1);
        chk("l1_state", 40'(bus.slot_state),         40'h01);
        chk("l1_x",     40'(bus.MissileX_all[9:0]),  40'd314);
        chk("l1_y",     40'(bus.MissileY_all[9:0]),  40'd394);
        tick();
        chk("l1_ack_off", 40'(bus.fire_ack),          40'd0);
        chk("l1_y1",      40'(bus.MissileY_all[9:0]), 40'd391);
        tick();
        chk("l1_y2",      40'(bus.MissileY_all[9:0]), 40'd388);

        // reset mid-flight, then hold the key: launches every 9 frames
        Reset = 1'b1;
        tick();
        chk("rst2_state", 40'(bus.slot_state), 40'h0);
        chk("rst2_y",     bus.MissileY_all,    40'h0);
        Reset = 1'b0;
        bus.keycode = 8'h1A;
        for (int f = 0; f < 38; f++) begin
            tick();
            n = (f / 9) + 1;
            if (n > 4) n = 4;
            es = 8'h00;
            for (int i = 0; i < n; i++) es[2*i +: 2] = 2'b01;
            chk($sformatf("rep_ack_f%0d", f),   40'(bus.fire_ack),
                40'((f % 9 == 0 && f < 36) ? 1 : 0));
            chk($sformatf("rep_state_f%0d", f), 40'(bus.slot_state), 40'(es));
        end
        chk("rep_x3", 40'(bus.MissileX_all[39:30]), 40'd314);
        chk("rep_y3", 40'(bus.MissileY_all[39:30]), 40'd364);
        bus.keycode = 8'h00;

        // top-of-screen retire and ShipY boundary
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.keycode = 8'h1A;
        bus.ShipY   = 10'd11;
        tick();
        bus.keycode = 8'h00;
        chk("ret_launch_y", 40'(bus.MissileY_all[9:0]), 40'd5);
        tick();
        chk("ret_y1",     40'(bus.MissileY_all[9:0]), 40'd2);
        chk("ret_state1", 40'(bus.slot_state),        40'h01);
        tick();
        chk("ret_state2", 40'(bus.slot_state),        40'h00);
        chk("ret_y2",     40'(bus.MissileY_all[9:0]), 40'd2);
        for (int f = 0; f < 6; f++) tick();
        bus.keycode = 8'h1A;
        bus.ShipY   = 10'd5;
        tick();
        chk("low_ship_ack",   40'(bus.fire_ack),   40'd0);
        chk("low_ship_state", 40'(bus.slot_state), 40'h00);
        bus.ShipY = 10'd6;
        tick();
        bus.keycode = 8'h00;
        chk("edge_ship_ack",   40'(bus.fire_ack),           40'd1);
        chk("edge_ship_state", 40'(bus.slot_state),         40'h01);
        chk("edge_ship_y",     40'(bus.MissileY_all[9:0]),  40'd0);
        tick();
        chk("edge_retire", 40'(bus.slot_state),        40'h00);
        chk("edge_y_hold", 40'(bus.MissileY_all[9:0]), 40'd0);

        // hit on slot1 at Y=200: four EXPLODE frames, re-hit ignored
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.keycode = 8'h1A;
        bus.ShipY   = 10'd400;
        tick();
        bus.keycode = 8'h00;
        for (int f = 0; f < 8; f++) tick();
        bus.keycode = 8'h1A;
        bus.ShipY   = 10'd206;
        tick();
        bus.keycode = 8'h00;
        chk("hit_launch_state", 40'(bus.slot_state),          40'h05);
        chk("hit_launch_y1",    40'(bus.MissileY_all[19:10]), 40'd200);
        bus.hit = 4'b0010;
        for (int f = 0; f < 4; f++) begin
            tick();
            chk($sformatf("expl_state_f%0d", f), 40'(bus.slot_state),          40'h09);
            chk($sformatf("expl_y_f%0d", f),     40'(bus.MissileY_all[19:10]), 40'd200);
        end
        tick();
        bus.hit = 4'b0000;
        chk("expl_done_state", 40'(bus.slot_state),          40'h01);
        chk("expl_done_y1",    40'(bus.MissileY_all[19:10]), 40'd200);
        chk("expl_slot0_y",    40'(bus.MissileY_all[9:0]),   40'd352);

        // hit beats retire at Y=1, then reset aborts the explosion
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.keycode = 8'h1A;
        bus.ShipY   = 10'd7;
        tick();
        bus.keycode = 8'h00;
        chk("hr_launch_y", 40'(bus.MissileY_all[9:0]), 40'd1);
        bus.hit = 4'b0001;
        tick();
        bus.hit = 4'b0000;
        chk("hr_state", 40'(bus.slot_state),        40'h02);
        chk("hr_y",     40'(bus.MissileY_all[9:0]), 40'd1);
        tick();
        chk("hr_state2", 40'(bus.slot_state), 40'h02);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("hr_rst_state", 40'(bus.slot_state), 40'h00);
        chk("hr_rst_x",     bus.MissileX_all,    40'h0);
        chk("hr_rst_y",     bus.MissileY_all,    40'h0);
        chk("hr_rst_ack",   40'(bus.fire_ack),   40'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
